instr_encoder: RTL and testbench

//  Inverse of decode-stage immediate extraction: packs opcode class, register fields, funct3 and a

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV load/addi/store/beq fields into a 32-bit word.
// Optional macro IMM_RANGE_CHECK_EN adds the immediate range check and error counter.
package codes_pkg;
  parameter int DATA_WIDTH = 64;
  parameter int WORD_WIDTH = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
endpackage

module instr_encoder #(
  parameter int DATA_WIDTH = codes_pkg::DATA_WIDTH,
  parameter int WORD_WIDTH = codes_pkg::WORD_WIDTH,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_fmt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  addr_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic [7:0]            err_count
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] instr_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  accept, xfer;
  logic                  is_i, is_s, is_b;
  logic [6:0]            op_i;

  assign in_ready = !valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = valid_q & out_ready;

  assign is_i = ~in_fmt[1];
  assign is_s = (in_fmt == 2'd2);
  assign is_b = (in_fmt == 2'd3);
  assign op_i = in_fmt[0] ? codes_pkg::OP_ADDI
                          : codes_pkg::OP_LOAD;

  // Field packing; immediate bits above the format width are dropped.
  always_comb begin
    word_d = '0;
    unique case (1'b1)
      is_i: word_d[31:0] = {in_imm[11:0], in_rs1,
                            in_funct3, in_rd, op_i};
      is_s: word_d[31:0] = {in_imm[11:5], in_rs2, in_rs1,
                            in_funct3, in_imm[4:0],
                            codes_pkg::OP_STORE};
      is_b: word_d[31:0] = {in_imm[12], in_imm[10:5],
                            in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11],
                            codes_pkg::OP_BEQ};
      default: word_d = '0;
    endcase
  end

  // Output valid and address counter next state; clear beats increment.
  always_comb begin
    valid_d = valid_q;
    if (accept)    valid_d = 1'b1;
    else if (xfer) valid_d = 1'b0;
    cnt_d = cnt_q;
    if (addr_clr)    cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  // Output stage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        instr_q <= word_d;
        addr_q  <= cnt_q;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;

`ifdef IMM_RANGE_CHECK_EN
  logic       i_ok, b_ok, err_d;
  logic       err_q;
  logic [7:0] ecnt_q, ecnt_d;

  assign i_ok = (in_imm[DATA_WIDTH-1:11] ==
                 {(DATA_WIDTH-11){in_imm[11]}});
  assign b_ok = (in_imm[DATA_WIDTH-1:12] ==
                 {(DATA_WIDTH-12){in_imm[12]}}) & ~in_imm[0];
  assign err_d = is_b ? ~b_ok : ~i_ok;

  // Count transferred error words, holding at 255.
  always_comb begin
    ecnt_d = ecnt_q;
    if (xfer & err_q & (ecnt_q != 8'hFF))
      ecnt_d = ecnt_q + 8'd1;
  end

  // Error flag follows its word; counter survives address clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      ecnt_q <= 8'd0;
    end else begin
      ecnt_q <= ecnt_d;
      if (accept) err_q <= err_d;
    end
  end

  assign out_err   = err_q;
  assign err_count = ecnt_q;
`else
  logic unused_imm;
  assign unused_imm = ^in_imm[DATA_WIDTH-1:13];
  assign out_err    = 1'b0;
  assign err_count  = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for instr_encoder.
// Built with ADDR_WIDTH=2 so address wrap is reached quickly.
module tb_instr_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        addr_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder #(
    .DATA_WIDTH(64),
    .WORD_WIDTH(32),
    .ADDR_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_fmt(in_fmt),
    .in_rd(in_rd),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_funct3(in_funct3),
    .in_imm(in_imm),
    .addr_clr(addr_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_addr(out_addr),
    .out_err(out_err),
    .err_count(err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [1:0] f,
                     input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic [2:0] f3,
                     input logic [63:0] imm);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
  endtask

  // One request, then returns on the negedge its word is on the output.
  task automatic send(input logic [1:0] f,
                      input logic [4:0] rd,
                      input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input logic [2:0] f3,
                      input logic [63:0] imm);
    @(negedge clk);
    drv(f, rd, rs1, rs2, f3, imm);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [1:0] exp_addr [5];

  initial begin
    exp_addr[0] = 2'd0;
    exp_addr[1] = 2'd1;
    exp_addr[2] = 2'd2;
    exp_addr[3] = 2'd0;
    exp_addr[4] = 2'd1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fmt    = 2'd0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_funct3 = '0;
    in_imm    = '0;
    addr_clr  = 1'b0;
    out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ecnt", 32'(err_count), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // addi -1, latency one cycle
    @(negedge clk);
    drv(2'd1, 5'd5, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b1;
    #1 chk("t1_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", out_instr, 32'hFFF00293);
    chk("t1_addr", 32'(out_addr), 32'd0);
    chk("t1_err", 32'(out_err), 32'd0);

    // store / beq / load / beq, address wraps 3 -> 0
    send(2'd2, 5'd0, 5'd2, 5'd6, 3'd3, 64'd8);
    chk("t2_st", out_instr, 32'h00613423);
    chk("t2_st_a", 32'(out_addr), 32'd1);
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, -64'sd4);
    chk("t2_beq", out_instr, 32'hFE208EE3);
    chk("t2_beq_a", 32'(out_addr), 32'd2);
    send(2'd0, 5'd1, 5'd2, 5'd0, 3'd2, 64'd16);
    chk("t2_ld", out_instr, 32'h01012083);
    chk("t2_ld_a", 32'(out_addr), 32'd3);
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 64'd8);
    chk("t2_beq8", out_instr, 32'h00208463);
    chk("t2_wrap_a", 32'(out_addr), 32'd0);

    // standalone clear
    @(negedge clk);
    addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);

    // back-to-back with a two-cycle stall
    @(negedge clk);
    drv(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    drv(2'd1, 5'd2, 5'd0, 5'd0, 3'd0, 64'd2);
    out_ready = 1'b0;
    #1 chk("t3_rdy0", 32'(in_ready), 32'd0);
    chk("t3_A", out_instr, 32'h00100093);
    chk("t3_A_a", 32'(out_addr), 32'd0);
    @(negedge clk);
    chk("t3_A_hold", out_instr, 32'h00100093);
    chk("t3_A_hold_a", 32'(out_addr), 32'd0);
    chk("t3_hold_v", 32'(out_valid), 32'd1);
    chk("t3_rdy0b", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t3_A_hold2", out_instr, 32'h00100093);
    out_ready = 1'b1;
    #1 chk("t3_rdy1", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("t3_B", out_instr, 32'h00200113);
    chk("t3_B_a", 32'(out_addr), 32'd1);
    drv(2'd1, 5'd3, 5'd0, 5'd0, 3'd0, 64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_C", out_instr, 32'h00300193);
    chk("t3_C_a", 32'(out_addr), 32'd2);
    @(negedge clk);
    chk("t3_drain", 32'(out_valid), 32'd0);

    // clear, then five accepts with clear on the third
    addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0)
        chk($sformatf("t4_a%0d", i - 1),
            32'(out_addr), 32'(exp_addr[i-1]));
      drv(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 64'(i));
      out_ready = 1'b1;
      addr_clr  = (i == 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    addr_clr = 1'b0;
    chk("t4_a4", 32'(out_addr), 32'(exp_addr[4]));

    // immediate range boundaries
    send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048);
    chk("t5_2048", out_instr, 32'h80000093);
    chk("t5_2048_e", 32'(out_err), 32'(EN));
    @(negedge clk);
    chk("t5_ecnt1", 32'(err_count), EN ? 32'd1 : 32'd0);
    send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 64'd3);
    chk("t5_b3", out_instr, 32'h00000163);
    chk("t5_b3_e", 32'(out_err), 32'(EN));
    send(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd2048);
    chk("t5_m2048", out_instr, 32'h80000013);
    chk("t5_m2048_e", 32'(out_err), 32'd0);
    chk("t5_ecnt2", 32'(err_count), EN ? 32'd2 : 32'd0);
    send(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 64'd2047);
    chk("t5_2047", out_instr, 32'h7FF00013);
    chk("t5_2047_e", 32'(out_err), 32'd0);
    send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 64'd4094);
    chk("t5_b4094", out_instr, 32'h7E000FE3);
    chk("t5_b4094_e", 32'(out_err), 32'd0);
    send(2'd2, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd2049);
    chk("t5_sm2049", out_instr, 32'h7E000FA3);
    chk("t5_sm2049_e", 32'(out_err), 32'(EN));

    // saturation: 260 more error words
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      drv(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 64'd4096);
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_sat", 32'(err_count), EN ? 32'd255 : 32'd0);

    // reset while a word is held
    send(2'd1, 5'd1, 5'd0, 5'd0, 3'd0, 64'd1);
    @(negedge clk);
    drv(2'd1, 5'd2, 5'd0, 5'd0, 3'd0, 64'd2);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t6_held_v", 32'(out_valid), 32'd1);
    chk("t6_held_a", 32'(out_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_v", 32'(out_valid), 32'd0);
    chk("t6_async_i", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd1, 5'd4, 5'd0, 5'd0, 3'd0, 64'd4);
    chk("t6_after", out_instr, 32'h00400213);
    chk("t6_after_a", 32'(out_addr), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
